// File: rtl/instr_readout.sv
// Read-out stage for the instruction register: streams a wrapping address range on valid/ready.
// Define INSTR_READOUT_CHECK_EN to build the opcode/operand result checker.

package instr_readout_pkg;
   localparam int unsigned OpW      = 4;
   localparam int unsigned OperandW = 8;
   localparam int unsigned ResultW  = 16;

   typedef logic [OpW-1:0]      opcode_t;
   // Operands are zero-extended into the result width before any arithmetic.
   typedef logic [OperandW-1:0] operand_t;
   typedef logic [ResultW-1:0]  result_t;
   typedef logic [4:0]          address_t;

   typedef struct packed {
      opcode_t  op;
      operand_t a;
      operand_t b;
      result_t  res;
   } instruction_t;

   localparam opcode_t OpZero  = 4'd0;
   localparam opcode_t OpPassA = 4'd1;
   localparam opcode_t OpPassB = 4'd2;
   localparam opcode_t OpAdd   = 4'd3;
   localparam opcode_t OpSub   = 4'd4;
   localparam opcode_t OpMult  = 4'd5;
   localparam opcode_t OpDiv   = 4'd6;
   localparam opcode_t OpMod   = 4'd7;
endpackage

module instr_readout
   import instr_readout_pkg::*;
#(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned CNT_W = 6,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [AW-1:0]    start_addr,
   input  logic [CNT_W-1:0] num_words,
   output logic [AW-1:0]    read_pointer,
   input  instruction_t     instruction_word,
   output logic             out_valid,
   input  logic             out_ready,
   output instruction_t     out_instr,
   output logic [AW-1:0]    out_addr,
   output logic             out_mismatch,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StRun   = 2'd1;
   localparam logic [1:0] StDrain = 2'd2;
   localparam logic [1:0] StFin   = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [AW-1:0]    rp_q, rp_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             valid_q, valid_d;
   instruction_t     instr_q, instr_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic             capture;
   logic             launch;

   assign launch = (state_q == StIdle) && start && (num_words != '0);

   always_comb begin
      state_d = state_q;
      rp_d    = rp_q;
      rem_d   = rem_q;
      valid_d = valid_q;
      instr_d = instr_q;
      addr_d  = addr_q;
      capture = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               if (num_words != '0) begin
                  state_d = StRun;
                  rp_d    = start_addr;
                  rem_d   = num_words;
               end else begin
                  state_d = StFin;
               end
            end
         end
         StRun: begin
            capture = !valid_q || out_ready;
            if (capture) begin
               instr_d = instruction_word;
               addr_d  = rp_q;
               valid_d = 1'b1;
               rp_d    = rp_q + 1'b1;
               rem_d   = rem_q - 1'b1;
               if (rem_q == CNT_W'(1)) state_d = StDrain;
            end
         end
         StDrain: begin
            // out_valid is always high here; only the final handshake is pending.
            if (out_ready) begin
               valid_d = 1'b0;
               state_d = StFin;
            end
         end
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         rp_q    <= '0;
         rem_q   <= '0;
         valid_q <= 1'b0;
         instr_q <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         rp_q    <= rp_d;
         rem_q   <= rem_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         addr_q  <= addr_d;
      end
   end

   assign read_pointer = rp_q;
   assign out_valid    = valid_q;
   assign out_instr    = instr_q;
   assign out_addr     = addr_q;
   assign busy         = (state_q != StIdle);
   assign done         = (state_q == StFin);

`ifdef INSTR_READOUT_CHECK_EN
   logic             mism_q, mism_d;
   logic [CNT_W-1:0] err_q, err_d;

   // Case inequality makes any X/Z in the stored result count as a mismatch.
   function automatic logic result_mismatch(input instruction_t w);
      result_t a, b, expv;
      logic    div0, legal;
      a     = result_t'(w.a);
      b     = result_t'(w.b);
      expv  = '0;
      div0  = (w.b == '0);
      legal = 1'b1;
      case (w.op)
         OpZero:  expv = '0;
         OpPassA: expv = a;
         OpPassB: expv = b;
         OpAdd:   expv = a + b;
         OpSub:   expv = a - b;
         OpMult:  expv = a * b;
         OpDiv:   expv = div0 ? '0 : a / b;
         OpMod:   expv = div0 ? '0 : a % b;
         default: legal = 1'b0;
      endcase
      if (!legal) return 1'b1;
      if (((w.op == OpDiv) || (w.op == OpMod)) && div0) return 1'b0;
      return (w.res !== expv);
   endfunction

   always_comb begin
      mism_d = mism_q;
      err_d  = err_q;
      if (launch) begin
         err_d = '0;
      end else if (capture) begin
         mism_d = result_mismatch(instruction_word);
         if (mism_d && (err_q != '1)) err_d = err_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mism_q <= 1'b0;
         err_q  <= '0;
      end else begin
         mism_q <= mism_d;
         err_q  <= err_d;
      end
   end

   assign out_mismatch = mism_q;
   assign err_count    = err_q;
`else
   assign out_mismatch = 1'b0;
   assign err_count    = '0;
`endif

endmodule

// File: tb/tb_instr_readout.sv
// Randomized self-checking bench for instr_readout against a queue-based reference model.
// Honours INSTR_READOUT_CHECK_EN for the expected mismatch/error-count behaviour.

module tb_instr_readout;
   import instr_readout_pkg::*;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   address_t     start_addr;
   logic [5:0]   num_words;
   address_t     read_pointer;
   instruction_t instruction_word;
   logic         out_valid;
   logic         out_ready;
   instruction_t out_instr;
   address_t     out_addr;
   logic         out_mismatch;
   logic         busy;
   logic         done;
   logic [5:0]   err_count;

   instruction_t mem [32];
   int           n_checks = 0;
   int           n_pass   = 0;
   int           n_fail   = 0;
   int           err_model = 0;

   always #5 clk = ~clk;

   assign instruction_word = mem[read_pointer];

   instr_readout #(.DEPTH(32), .CNT_W(6)) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .start_addr       (start_addr),
      .num_words        (num_words),
      .read_pointer     (read_pointer),
      .instruction_word (instruction_word),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_instr        (out_instr),
      .out_addr         (out_addr),
      .out_mismatch     (out_mismatch),
      .busy             (busy),
      .done             (done),
      .err_count        (err_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic result_t ref_result(input instruction_t w);
      int unsigned a, b, r;
      a = w.a;
      b = w.b;
      case (w.op)
         OpZero:  r = 0;
         OpPassA: r = a;
         OpPassB: r = b;
         OpAdd:   r = a + b;
         OpSub:   r = a - b;
         OpMult:  r = a * b;
         OpDiv:   r = (b == 0) ? 0 : a / b;
         OpMod:   r = (b == 0) ? 0 : a % b;
         default: r = 0;
      endcase
      return result_t'(r);
   endfunction

   function automatic bit ref_mismatch(input instruction_t w);
`ifdef INSTR_READOUT_CHECK_EN
      if (w.op > OpMod) return 1'b1;
      if ((w.op == OpDiv || w.op == OpMod) && w.b == 0) return 1'b0;
      return (w.res != ref_result(w));
`else
      return 1'b0;
`endif
   endfunction

   function automatic instruction_t make_word(input opcode_t op, input operand_t a,
                                              input operand_t b, input bit corrupt);
      instruction_t w;
      w.op  = op;
      w.a   = a;
      w.b   = b;
      w.res = ref_result(w);
      if (corrupt) w.res = w.res ^ result_t'($urandom_range(1, 16'hFFFF));
      return w;
   endfunction

   task automatic fill_random();
      for (int i = 0; i < 32; i++) begin
         mem[i] = make_word(opcode_t'($urandom_range(0, 9)), operand_t'($urandom),
                            ($urandom_range(0, 3) == 0) ? 8'd0 : operand_t'($urandom),
                            ($urandom_range(0, 4) == 0));
      end
   endtask

   // mode 0: always ready, 1: ready low 3 cycles after 2nd beat, 2: random ready + stray starts
   task automatic run(input int sa, input int n, input int mode);
      instruction_t exp_w[$];
      int           exp_a[$];
      bit           exp_m[$];
      int           beats, last_hs, cyc, drop_left, cnt;
      bit           done_seen, prev_stall, hs;
      instruction_t prev_instr;
      address_t     prev_addr, prev_rp, ad;

      cnt = 0;
      for (int i = 0; i < n; i++) begin
         ad = address_t'((sa + i) % 32);
         exp_w.push_back(mem[ad]);
         exp_a.push_back(int'(ad));
         exp_m.push_back(ref_mismatch(mem[ad]));
         if (ref_mismatch(mem[ad])) cnt++;
      end
      if (n > 0) err_model = (cnt > 63) ? 63 : cnt;

      start      = 1'b1;
      start_addr = address_t'(sa);
      num_words  = 6'(n);
      out_ready  = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
      start_addr = address_t'($urandom);
      num_words  = 6'($urandom);

      if (n == 0) begin
         @(negedge clk);
         check("zero_done", done, 1'b1);
         check("zero_no_valid", out_valid, 1'b0);
         @(posedge clk); #1;
         @(negedge clk);
         check("zero_done_pulse", done, 1'b0);
         check("zero_idle", busy, 1'b0);
         check("zero_err_hold", err_count, err_model);
         return;
      end

      beats = 0; last_hs = -10; cyc = 0; drop_left = 0;
      done_seen = 0; prev_stall = 0;
      while (!done_seen && cyc < 400) begin
         if (mode == 0) out_ready = 1'b1;
         else if (mode == 1) begin
            out_ready = (drop_left == 0);
            if (drop_left > 0) drop_left--;
         end else begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (beats < n - 1 && cyc > 1 && $urandom_range(0, 7) == 0) begin
               start      = 1'b1;
               start_addr = address_t'($urandom);
               num_words  = 6'($urandom_range(1, 32));
            end
         end
         @(negedge clk);
         if (cyc == 0) begin
            check("start_rp", read_pointer, address_t'(sa));
            check("start_busy", busy, 1'b1);
            check("start_no_valid", out_valid, 1'b0);
         end
         if (prev_stall) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_instr", out_instr, prev_instr);
            check("stall_addr", out_addr, prev_addr);
            check("stall_rp", read_pointer, prev_rp);
         end
         check("done", done, (beats == n) && (cyc == last_hs + 1));
         if (done) begin
            done_seen = 1;
            check("beat_count", beats, n);
            check("err_count", err_count, err_model);
         end
         hs = out_valid && out_ready;
         if (hs) begin
            if (exp_w.size() == 0) check("extra_beat", 1'b1, 1'b0);
            else begin
               check("out_instr", out_instr, exp_w.pop_front());
               check("out_addr", out_addr, exp_a.pop_front());
               check("out_mismatch", out_mismatch, exp_m.pop_front());
               if (mode == 0) check("back_to_back", cyc, beats + 1);
            end
            beats++;
            last_hs = cyc;
            if (mode == 1 && beats == 2) drop_left = 3;
         end
         prev_stall = out_valid && !out_ready;
         prev_instr = out_instr;
         prev_addr  = out_addr;
         prev_rp    = read_pointer;
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
      end
      if (!done_seen) check("timeout", 1'b0, 1'b1);
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      start_addr = '0;
      num_words  = '0;
      out_ready  = 1'b0;
      for (int i = 0; i < 32; i++) mem[i] = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_rp", read_pointer, 5'd0);
      check("rst_instr", out_instr, 36'd0);
      check("rst_addr", out_addr, 5'd0);
      check("rst_mismatch", out_mismatch, 1'b0);
      check("rst_err", err_count, 6'd0);
      @(posedge clk); #1;

      fill_random();
      mem[2] = make_word(OpAdd, 8'd5, 8'd3, 1'b0);
      mem[3] = make_word(OpSub, 8'd10, 8'd4, 1'b0);
      mem[4] = make_word(OpMult, 8'd7, 8'd6, 1'b0);
      mem[5] = make_word(OpPassB, 8'd1, 8'd9, 1'b0);
      run(2, 4, 0);
      run(30, 4, 0);
      run(2, 4, 1);

      mem[10] = '{op: OpAdd, a: 8'd5, b: 8'd3, res: 16'd9};
      mem[11] = '{op: OpDiv, a: 8'd9, b: 8'd0, res: 16'hDEAD};
      run(10, 2, 0);
      run(7, 0, 0);

      for (int r = 0; r < 6; r++) begin
         fill_random();
         run($urandom_range(0, 31), $urandom_range(1, 32), 2);
      end
      fill_random();
      run($urandom_range(0, 31), 32, 1);

      // Reset in the middle of a stream abandons it without a done pulse.
      start = 1'b1; start_addr = 5'd20; num_words = 6'd10; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      err_model = 0;
      @(negedge clk);
      check("midrst_valid", out_valid, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_rp", read_pointer, 5'd0);
      check("midrst_err", err_count, 6'd0);
      check("midrst_done", done, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      check("midrst_no_done", done, 1'b0);
      @(posedge clk); #1;

      fill_random();
      run(31, 3, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
